alu_decoder: RTL
================

# alu_decoder

Decode stage that produces the 10-bit one-hot ALU operation code and operand controls consumed by the integer ALU. It accepts RV32I OP (0110011) and OP-IMM (0010011) instruction words over a valid/ready handshake, decodes them, and holds the result in a single-entry output register with its own valid/ready handshake. Unsupported encodings are flagged illegal and counted. The block sits between instruction fetch and the register-read/ALU stage.

## Interface
- `CNT_W`, default 8: width of the saturating illegal-instruction counter.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  `in_instr` is valid.
- `in_ready`  output  1  decoder can accept this cycle.
- `in_instr`  input  32  RV32I instruction word.
- `out_valid`  output  1  decoded bundle is valid.
- `out_ready`  input  1  downstream accepts the bundle.
- `alu_op`  output  10  one-hot: add=1, sub=2, xor=4, or=8, and=16, sll=32, srl=64, sra=128, slt=256, sltu=512; 0 when illegal.
- `use_imm`  output  1  operand B is `imm`, not rs2.
- `imm`  output  32  sign-extended I-immediate; for shifts `{27'b0, instr[24:20]}`; 0 for R-type.
- `rs1`, `rs2`, `rd`  output  5 each  register fields; `rs2` is 0 for OP-IMM.
- `illegal`  output  1  bundle is an illegal/unsupported encoding.
- `illegal_cnt`  output  CNT_W  saturating count of illegal bundles accepted.

## Operation
- Fields: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- funct3 map: 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
- OP (R-type): funct7=0000000 → base op. funct7=0100000 is legal only for funct3 000 (sub) and 101 (sra). Any other funct7 is illegal. `use_imm`=0.
- OP-IMM: funct3 000 always add (no subi). funct3 001 requires funct7=0000000. funct3 101: funct7 0000000→srl, 0100000→sra, otherwise illegal. Other funct3 values ignore funct7. `use_imm`=1.
- Any other opcode is illegal.
- Illegal bundles: `alu_op`=0, `use_imm`=0, `imm`=0, `illegal`=1. `rs1`/`rs2`/`rd` still carry the raw fields.
- Output register states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - Load when `in_valid && in_ready`.
  - EMPTY→FULL on load.
  - FULL→EMPTY on `out_ready` with no load.
  - FULL→FULL on a simultaneous drain and load; the new bundle replaces the old one in the same edge.
- `illegal_cnt` increments by 1 on each load whose decode is illegal and saturates at 2^CNT_W−1 (no wrap).

## Timing
- `in_ready` = !`out_valid` || `out_ready`. It is combinational, with no combinational path from `in_valid`.
- Latency is 1 cycle: an instruction accepted at edge N is presented with `out_valid`=1 after edge N.
- With `out_ready` held high, throughput is 1 instruction per cycle.
- While `out_valid`=1 and `out_ready`=0, all outputs hold stable and `in_ready`=0.
- Asynchronous reset clears `out_valid`, `alu_op`, `use_imm`, `imm`, `rs1`, `rs2`, `rd`, `illegal` and `illegal_cnt` to 0 immediately. A bundle in flight at reset is discarded. `in_ready`=1 once reset deasserts.
- Outputs come directly from flops; only `in_ready` is combinational.

## Test plan
- ADD then SUB: `0x002081B3` then `0x402081B3`, back-to-back with `out_ready`=1 → `alu_op` 1 then 2, rs1=1, rs2=2, rd=3, `use_imm`=0, 1 bundle/cycle.
- ADDI: `0xFFF00293` → `alu_op`=1, `use_imm`=1, `imm`=0xFFFFFFFF, rd=5, rs1=0, rs2=0.
- SRAI: `0x40715093` → `alu_op`=128, `imm`=7, rd=1, rs1=2.
- Illegal: `0x40001013` (SLLI with funct7=0100000), then `0x00000073` → `illegal`=1, `alu_op`=0 for both, `illegal_cnt`=2. With CNT_W=2, five illegal loads leave the counter at 3.
- Backpressure: hold `out_ready`=0 for 3 cycles after a load → `in_ready`=0 and outputs unchanged. Raise `out_ready` with `in_valid`=1 → old bundle drains and the new one loads on the same edge.
- Reset mid-stream: assert `rst` while FULL → `out_valid`, `alu_op`, `illegal_cnt` go to 0 without waiting for a clock edge. The first instruction after deassert decodes normally.

Source files
------------

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - RV32I OP/OP-IMM decode into a one-hot ALU op code
// with a single-entry valid/ready output register and a saturating illegal counter.
module alu_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [9:0]       alu_op,
    output logic             use_imm,
    output logic [31:0]      imm,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [9:0] OP_ADD  = 10'd1;
    localparam logic [9:0] OP_SUB  = 10'd2;
    localparam logic [9:0] OP_XOR  = 10'd4;
    localparam logic [9:0] OP_OR   = 10'd8;
    localparam logic [9:0] OP_AND  = 10'd16;
    localparam logic [9:0] OP_SLL  = 10'd32;
    localparam logic [9:0] OP_SRL  = 10'd64;
    localparam logic [9:0] OP_SRA  = 10'd128;
    localparam logic [9:0] OP_SLT  = 10'd256;
    localparam logic [9:0] OP_SLTU = 10'd512;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {EMPTY, FULL} state_t;
    state_t state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [9:0] base_op;
    logic [9:0] d_op;
    logic       d_use_imm;
    logic [31:0] d_imm;
    logic [4:0] d_rs2;
    logic       d_legal;
    logic       load;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    always_comb begin
        base_op = OP_ADD;
        case (funct3)
            3'b000: base_op = OP_ADD;
            3'b001: base_op = OP_SLL;
            3'b010: base_op = OP_SLT;
            3'b011: base_op = OP_SLTU;
            3'b100: base_op = OP_XOR;
            3'b101: base_op = OP_SRL;
            3'b110: base_op = OP_OR;
            3'b111: base_op = OP_AND;
            default: base_op = OP_ADD;
        endcase
    end

    // Legality first, then operand controls; illegal bundles keep only raw register fields.
    always_comb begin
        d_op      = '0;
        d_use_imm = 1'b0;
        d_imm     = '0;
        d_rs2     = in_instr[24:20];
        d_legal   = 1'b0;
        if (opcode == OPC_OP) begin
            if (funct7 == F7_ZERO) begin
                d_legal = 1'b1;
                d_op    = base_op;
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                d_legal = 1'b1;
                d_op    = OP_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                d_legal = 1'b1;
                d_op    = OP_SRA;
            end
        end else if (opcode == OPC_OP_IMM) begin
            case (funct3)
                3'b001: begin
                    d_legal = (funct7 == F7_ZERO);
                    d_op    = OP_SLL;
                end
                3'b101: begin
                    d_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    d_op    = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                end
                default: begin
                    d_legal = 1'b1;
                    d_op    = base_op;
                end
            endcase
            if (d_legal) begin
                d_use_imm = 1'b1;
                d_rs2     = '0;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    d_imm = {27'b0, in_instr[24:20]};
                end else begin
                    d_imm = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end else begin
                d_op = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            out_valid   <= 1'b0;
            alu_op      <= '0;
            use_imm     <= 1'b0;
            imm         <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (!load && out_ready) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
            if (load) begin
                alu_op  <= d_op;
                use_imm <= d_use_imm;
                imm     <= d_imm;
                rs1     <= in_instr[19:15];
                rs2     <= d_rs2;
                rd      <= in_instr[11:7];
                illegal <= !d_legal;
                if (!d_legal && illegal_cnt != CNT_MAX) begin
                    illegal_cnt <= illegal_cnt + 1'b1;
                end
            end
        end
    end

endmodule
